// File: rtl/reg_file_sb.sv
// reg_file_sb: 2-read/1-write register file with hardwired x0, optional write bypass and pending-write scoreboard
module reg_file_sb #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int AW     = 5,
    parameter int BYPASS = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rg_wrt_en,
    input  logic [AW-1:0]   rg_wrt_dest,
    input  logic [XLEN-1:0] rg_wrt_data,
    input  logic [AW-1:0]   rg_rd_addr1,
    input  logic [AW-1:0]   rg_rd_addr2,
    output logic [XLEN-1:0] rg_rd_data1,
    output logic [XLEN-1:0] rg_rd_data2,
    input  logic            sb_set_en,
    input  logic [AW-1:0]   sb_set_addr,
    output logic            rd_pending1,
    output logic            rd_pending2,
    output logic            ready
);
    localparam int IW = $clog2(NREGS);

    typedef enum logic {INIT, RUN} state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     init_idx_q, init_idx_d;
    logic              ready_q, ready_d;
    logic [NREGS-1:0]  sb_q, sb_d;
    logic [XLEN-1:0]   regs_q [NREGS];
    logic [XLEN-1:0]   regs_d [NREGS];
    logic              run, wr_ok, set_ok, byp1, byp2;

    function automatic logic valid(input logic [AW-1:0] a);
        return a != '0 && 32'(a) < NREGS;
    endfunction

    function automatic logic [IW-1:0] idx(input logic [AW-1:0] a);
        return a[IW-1:0];
    endfunction

    assign run    = state_q == RUN;
    assign wr_ok  = run && rg_wrt_en && valid(rg_wrt_dest);
    assign set_ok = run && sb_set_en && valid(sb_set_addr);
    assign ready  = ready_q;

    // read ports: zero for x0/out-of-range/INIT, forward same-cycle write when bypass is enabled
    always_comb begin
        byp1 = BYPASS != 0 && wr_ok && rg_wrt_dest == rg_rd_addr1;
        byp2 = BYPASS != 0 && wr_ok && rg_wrt_dest == rg_rd_addr2;
        rg_rd_data1 = !run || !valid(rg_rd_addr1) ? '0 : byp1 ? rg_wrt_data : regs_q[idx(rg_rd_addr1)];
        rg_rd_data2 = !run || !valid(rg_rd_addr2) ? '0 : byp2 ? rg_wrt_data : regs_q[idx(rg_rd_addr2)];
        rd_pending1 = run && valid(rg_rd_addr1) && sb_q[idx(rg_rd_addr1)]
                      && !(byp1 && !(set_ok && sb_set_addr == rg_rd_addr1));
        rd_pending2 = run && valid(rg_rd_addr2) && sb_q[idx(rg_rd_addr2)]
                      && !(byp2 && !(set_ok && sb_set_addr == rg_rd_addr2));
    end

    // next state: sequential clear in INIT, writes and scoreboard set/clear (set wins) in RUN
    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        ready_d    = ready_q;
        sb_d       = sb_q;
        regs_d     = regs_q;
        if (!run) begin
            regs_d[idx(init_idx_q)] = '0;
            init_idx_d = init_idx_q + AW'(1);
            if (32'(init_idx_q) == NREGS - 1) begin
                state_d = RUN;
                ready_d = 1'b1;
            end
        end else begin
            if (wr_ok) regs_d[idx(rg_wrt_dest)] = rg_wrt_data;
            for (int i = 1; i < NREGS; i++)
                sb_d[i] = (set_ok && 32'(sb_set_addr) == i)
                          || (sb_q[i] && !(wr_ok && 32'(rg_wrt_dest) == i));
        end
    end

    // control state and scoreboard; reset restarts the clear from index 0
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= INIT;
            init_idx_q <= '0;
            ready_q    <= 1'b0;
            sb_q       <= '0;
        end else begin
            state_q    <= state_d;
            init_idx_q <= init_idx_d;
            ready_q    <= ready_d;
            sb_q       <= sb_d;
        end
    end

    // register storage is left alone on the reset edge itself
    always_ff @(posedge clk) begin
        if (!rst) regs_q <= regs_d;
    end
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed vector bench for reg_file_sb (bypass, no-bypass and 16-register instances)
module tb_reg_file_sb;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        we = 1'b0;
    logic [4:0]  dest = '0;
    logic [31:0] wdata = '0;
    logic [4:0]  a1 = '0, a2 = '0;
    logic        se = 1'b0;
    logic [4:0]  sa = '0;

    logic [31:0] d1, d2, nb_d1, nb_d2, nr_d1, nr_d2;
    logic        p1, p2, nb_p1, nb_p2, nr_p1, nr_p2;
    logic        rdy, nb_rdy, nr_rdy;

    int nvec = 0;
    int nfail = 0;
    int cnt, cnt_nr;

    always #5 clk = ~clk;

    reg_file_sb u_dut (
        .clk(clk), .rst(rst), .rg_wrt_en(we), .rg_wrt_dest(dest), .rg_wrt_data(wdata),
        .rg_rd_addr1(a1), .rg_rd_addr2(a2), .rg_rd_data1(d1), .rg_rd_data2(d2),
        .sb_set_en(se), .sb_set_addr(sa), .rd_pending1(p1), .rd_pending2(p2), .ready(rdy)
    );

    reg_file_sb #(.BYPASS(0)) u_nb (
        .clk(clk), .rst(rst), .rg_wrt_en(we), .rg_wrt_dest(dest), .rg_wrt_data(wdata),
        .rg_rd_addr1(a1), .rg_rd_addr2(a2), .rg_rd_data1(nb_d1), .rg_rd_data2(nb_d2),
        .sb_set_en(se), .sb_set_addr(sa), .rd_pending1(nb_p1), .rd_pending2(nb_p2), .ready(nb_rdy)
    );

    reg_file_sb #(.NREGS(16), .AW(5)) u_nr (
        .clk(clk), .rst(rst), .rg_wrt_en(we), .rg_wrt_dest(dest), .rg_wrt_data(wdata),
        .rg_rd_addr1(a1), .rg_rd_addr2(a2), .rg_rd_data1(nr_d1), .rg_rd_data2(nr_d2),
        .sb_set_en(se), .sb_set_addr(sa), .rd_pending1(nr_p1), .rd_pending2(nr_p2), .ready(nr_rdy)
    );

    typedef struct {
        logic        we;
        logic [4:0]  dest;
        logic [31:0] data;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic        se;
        logic [4:0]  sa;
        logic [31:0] d1;
        logic [31:0] d2;
        logic        p1;
        logic        p2;
        logic [31:0] nbd;
        logic        nbp;
    } vec_t;

    vec_t tv [18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0; dest = '0; wdata = '0; se = 1'b0; sa = '0;
    endtask

    task automatic run_init(output int c, output int cn);
        c = 0;
        cn = 0;
        while (!rdy && c < 64) begin
            step();
            c++;
            if (nr_rdy && cn == 0) cn = c;
        end
    endtask

    initial begin
        tv[0]  = '{0, 0,  32'h0,        5,  0,  0, 0, 32'h0,    32'h0,    0, 0, 32'h0,    0};
        tv[1]  = '{1, 0,  32'hDEADBEEF, 0,  0,  1, 0, 32'h0,    32'h0,    0, 0, 32'h0,    0};
        tv[2]  = '{0, 0,  32'h0,        0,  5,  0, 0, 32'h0,    32'h0,    0, 0, 32'h0,    0};
        tv[3]  = '{1, 7,  32'h1234,     7,  7,  0, 0, 32'h1234, 32'h1234, 0, 0, 32'h0,    0};
        tv[4]  = '{0, 0,  32'h0,        7,  7,  0, 0, 32'h1234, 32'h1234, 0, 0, 32'h1234, 0};
        tv[5]  = '{0, 0,  32'h0,        3,  7,  1, 3, 32'h0,    32'h1234, 0, 0, 32'h0,    0};
        tv[6]  = '{0, 0,  32'h0,        3,  3,  0, 0, 32'h0,    32'h0,    1, 1, 32'h0,    1};
        tv[7]  = '{0, 0,  32'h0,        3,  7,  0, 0, 32'h0,    32'h1234, 1, 0, 32'h0,    1};
        tv[8]  = '{1, 3,  32'hAAAA,     3,  3,  0, 0, 32'hAAAA, 32'hAAAA, 0, 0, 32'h0,    1};
        tv[9]  = '{0, 0,  32'h0,        3,  3,  0, 0, 32'hAAAA, 32'hAAAA, 0, 0, 32'hAAAA, 0};
        tv[10] = '{1, 3,  32'hBBBB,     3,  3,  1, 3, 32'hBBBB, 32'hBBBB, 0, 0, 32'hAAAA, 0};
        tv[11] = '{0, 0,  32'h0,        3,  3,  0, 0, 32'hBBBB, 32'hBBBB, 1, 1, 32'hBBBB, 1};
        tv[12] = '{1, 3,  32'hCCCC,     3,  3,  1, 3, 32'hCCCC, 32'hCCCC, 1, 1, 32'hBBBB, 1};
        tv[13] = '{1, 3,  32'hDDDD,     3,  9,  1, 9, 32'hDDDD, 32'h0,    0, 0, 32'hCCCC, 1};
        tv[14] = '{0, 0,  32'h0,        3,  9,  0, 0, 32'hDDDD, 32'h0,    0, 1, 32'hDDDD, 0};
        tv[15] = '{1, 31, 32'hF00D,     31, 30, 0, 0, 32'hF00D, 32'h0,    0, 0, 32'h0,    0};
        tv[16] = '{1, 4,  32'hA5,       4,  31, 1, 4, 32'hA5,   32'hF00D, 0, 0, 32'h0,    0};
        tv[17] = '{0, 0,  32'h0,        4,  31, 0, 0, 32'hA5,   32'hF00D, 1, 0, 32'hA5,   1};

        // power-up reset, with a write and scoreboard set to x5 held throughout INIT
        rst = 1'b1;
        step();
        rst = 1'b0;
        we = 1'b1; dest = 5; wdata = 32'h55; se = 1'b1; sa = 5; a1 = 5; a2 = 0;
        #2;
        chk("ready_after_rst", 32'(rdy), 32'h0);
        chk("nr_ready_after_rst", 32'(nr_rdy), 32'h0);
        chk("init_rd_data1", d1, 32'h0);
        chk("init_pending1", 32'(p1), 32'h0);
        run_init(cnt, cnt_nr);
        chk("init_cycles_32", cnt, 32);
        chk("init_cycles_16", cnt_nr, 16);
        idle();

        for (int i = 0; i < 18; i++) begin
            we = tv[i].we; dest = tv[i].dest; wdata = tv[i].data;
            a1 = tv[i].a1; a2 = tv[i].a2; se = tv[i].se; sa = tv[i].sa;
            #2;
            chk($sformatf("v%0d_d1", i), d1, tv[i].d1);
            chk($sformatf("v%0d_d2", i), d2, tv[i].d2);
            chk($sformatf("v%0d_p1", i), 32'(p1), 32'(tv[i].p1));
            chk($sformatf("v%0d_p2", i), 32'(p2), 32'(tv[i].p2));
            chk($sformatf("v%0d_nb_d1", i), nb_d1, tv[i].nbd);
            chk($sformatf("v%0d_nb_p1", i), 32'(nb_p1), 32'(tv[i].nbp));
            step();
        end

        // address 20 is out of range for the 16-register instance and must not alias onto x4
        we = 1'b1; dest = 20; wdata = 32'h777; se = 1'b1; sa = 20; a1 = 20; a2 = 4;
        #2;
        chk("nr_oor_d1_same", nr_d1, 32'h0);
        chk("nr_oor_p1_same", 32'(nr_p1), 32'h0);
        chk("nr_x4_d2_same", nr_d2, 32'hA5);
        chk("x20_bypass_d1", d1, 32'h777);
        step();
        idle();
        #2;
        chk("nr_oor_d1_next", nr_d1, 32'h0);
        chk("nr_oor_p1_next", 32'(nr_p1), 32'h0);
        chk("nr_x4_d2_next", nr_d2, 32'hA5);
        chk("nr_x4_p2_next", 32'(nr_p2), 32'h1);
        chk("x20_d1_next", d1, 32'h777);
        chk("x20_p1_next", 32'(p1), 32'h1);
        step();

        // reset in RUN with x4=0xA5 and x4 pending
        a1 = 4; a2 = 31;
        #2;
        chk("pre_rst_x4", d1, 32'hA5);
        chk("pre_rst_p4", 32'(p1), 32'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #2;
        chk("midrst_ready", 32'(rdy), 32'h0);
        chk("midrst_p1", 32'(p1), 32'h0);
        chk("midrst_d1", d1, 32'h0);
        run_init(cnt, cnt_nr);
        chk("midrst_cycles_32", cnt, 32);
        chk("midrst_cycles_16", cnt_nr, 16);
        #2;
        chk("midrst_x4_cleared", d1, 32'h0);
        chk("midrst_x4_pending", 32'(p1), 32'h0);
        chk("midrst_x31_cleared", d2, 32'h0);
        chk("midrst_nr_x4_cleared", nr_d1, 32'h0);
        chk("midrst_nb_x4_cleared", nb_d1, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised successor to the core's 2-read/1-write register file, for the pipelined core.
- Adds hardwired-zero register 0, optional write-to-read bypass and a per-register pending-write scoreboard for hazard detection.
- Reset starts a sequential clear that zeroes one register per cycle; `ready` rises when the clear completes.
- Sits between decode (reads and scoreboard set) and writeback (write and scoreboard clear).

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers (2..2^AW).
- AW, 5, address width; must satisfy 2^AW >= NREGS.
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads return stored value only.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- rg_wrt_en  in  1  write enable (writeback).
- rg_wrt_dest  in  AW  write address.
- rg_wrt_data  in  XLEN  write data.
- rg_rd_addr1  in  AW  read port 1 address.
- rg_rd_addr2  in  AW  read port 2 address.
- rg_rd_data1  out  XLEN  read port 1 data (combinational).
- rg_rd_data2  out  XLEN  read port 2 data (combinational).
- sb_set_en  in  1  mark sb_set_addr as pending (instruction issued with destination).
- sb_set_addr  in  AW  destination being marked pending.
- rd_pending1  out  1  register at rg_rd_addr1 has an outstanding write.
- rd_pending2  out  1  register at rg_rd_addr2 has an outstanding write.
- ready  out  1  clear sequence done; block accepts writes and scoreboard updates.

Behaviour:
- Reset (rst=1 at edge):
  - state <= INIT, init_idx <= 0, ready <= 0, all scoreboard bits <= 0.
  - Register contents are not touched by reset itself.
  - rst asserted mid-INIT or mid-RUN restarts INIT from index 0.
- INIT state:
  - Each cycle with rst=0: reg[init_idx] <= 0, init_idx++.
  - On the cycle that writes index NREGS-1: state <= RUN, ready <= 1.
  - INIT therefore occupies exactly NREGS cycles after rst deasserts; ready is 1 from the next edge.
  - During INIT: rg_wrt_en and sb_set_en are ignored; rg_rd_data1/2 = 0; rd_pending1/2 = 0.
- RUN state:
  - Write: rg_wrt_en=1 and 0 < rg_wrt_dest < NREGS -> reg[rg_wrt_dest] <= rg_wrt_data at the edge.
  - Writes to address 0 or to addresses >= NREGS are dropped.
  - Read: rg_rd_dataN = 0 if the address is 0 or >= NREGS; otherwise reg[addr].
  - BYPASS=1: if rg_wrt_en=1, rg_wrt_dest==addr, addr valid and nonzero, then rg_rd_dataN = rg_wrt_data in the same cycle.
  - Both read ports may target the same address; each resolves independently.
- Scoreboard (one bit per register, RUN only):
  - sb_set_en=1 with a valid nonzero address -> bit set at the edge.
  - rg_wrt_en=1 with a valid nonzero address -> bit cleared at the edge.
  - Set and clear of the same address in the same cycle: set wins (a new producer was issued); bit = 1.
  - Set and clear of different addresses in the same cycle: both take effect.
  - Bit 0 and out-of-range addresses are never set.
  - rd_pendingN = sb[addr] for a valid nonzero addr, else 0.
  - BYPASS=1: rd_pendingN is additionally masked to 0 when a same-cycle write to addr is occurring (the data is forwarded), unless sb_set_en targets the same addr in that cycle.
- Latency: reads are 0-cycle combinational; writes and scoreboard changes are visible in the cycle after the edge (or the same cycle via bypass).
- State encoding: 2 states (INIT, RUN); init_idx is AW bits and holds its value in RUN.

Test Plan:
- Reset/init, NREGS=32: pulse rst 1 cycle -> ready=0 for exactly 32 cycles, then 1; all registers read 0; a write of 0x55 to x5 attempted during INIT is lost (x5 reads 0 after ready).
- Zero register: RUN, write 0xDEADBEEF to x0 with sb_set_en on x0 -> rg_rd_data1(addr 0)=0, rd_pending1=0.
- Bypass: BYPASS=1, write x7=0x1234 while rg_rd_addr1=rg_rd_addr2=7 -> both data=0x1234 in the same cycle. Repeat with BYPASS=0 -> old value that cycle, 0x1234 the next cycle.
- Scoreboard: set x3 in cycle 1 -> rd_pending1(addr 3)=1 from cycle 2. Write x3 in cycle 5 -> pending masked in cycle 5 (BYPASS=1), 0 from cycle 6. Simultaneous set and write of x3 -> pending stays 1.
- Mid-operation reset: rst asserted in RUN with x4=0xA5 and sb[4]=1 -> ready=0, pending=0; after 32 cycles x4=0.
- Narrow config: NREGS=16, AW=5 -> write to address 20 dropped, read of address 20 returns 0, INIT lasts 16 cycles.
